// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage:
// FSM state encodings, PC step and the NOP encoding.
package fetch_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_HOLD = 2'd2
    } fetch_state_t;

    localparam int PC_INCREMENT    = 4;
    localparam int NOP_INSTRUCTION = 0;

endpackage

// File: rtl/pc_register.sv
// Program counter flop for the fetch stage.
// Redirect load has priority over the +4 increment.
module pc_register
    import fetch_pkg::*;
#(
    parameter int                  W        = 20,
    parameter logic [W-1:0]        RESET_PC = '0
) (
    input  logic         clk,
    input  logic         i_rst,
    input  logic         i_load,
    input  logic [W-1:0] i_target,
    input  logic         i_inc,
    output logic [W-1:0] o_pc_next
);

    logic [W-1:0] r_pc;

    // Next PC: redirect, else increment (wraps naturally), else hold
    always_comb begin
        o_pc_next = r_pc;
        if (i_load)
            o_pc_next = i_target;
        else if (i_inc)
            o_pc_next = r_pc + W'(PC_INCREMENT);
    end

    // PC state with synchronous reset
    always_ff @(posedge clk) begin
        if (i_rst)
            r_pc <= RESET_PC;
        else
            r_pc <= o_pc_next;
    end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: request/ack memory FSM feeding IF/ID.
// Define FETCH_FLUSH_EN to squash instructions fetched before a redirect.
module instruction_fetch
    import fetch_pkg::*;
#(
    parameter int                          PC_DATA_WIDTH     = 20,
    parameter int                          INSTRUCTION_WIDTH = 32,
    parameter logic [PC_DATA_WIDTH-1:0]    RESET_PC          = '0
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic                         stall,
    input  logic                         branch_taken,
    input  logic [PC_DATA_WIDTH-1:0]     branch_target,
    output logic                         inst_mem_req,
    output logic [PC_DATA_WIDTH-1:0]     inst_mem_addr,
    input  logic                         inst_mem_ack,
    input  logic [INSTRUCTION_WIDTH-1:0] inst_mem_rdata,
    output logic [PC_DATA_WIDTH-1:0]     pc_out,
    output logic [INSTRUCTION_WIDTH-1:0] inst_out,
    output logic                         inst_valid,
    output logic                         fetch_busy
);

    localparam logic [INSTRUCTION_WIDTH-1:0] W_NOP =
        INSTRUCTION_WIDTH'(NOP_INSTRUCTION);

    fetch_state_t                r_state;
    logic [PC_DATA_WIDTH-1:0]    r_addr;
    logic                        r_redir;
    logic [PC_DATA_WIDTH-1:0]    w_pc_next;
    logic                        w_in_req;
    logic                        w_ack_req;
    logic                        w_inc;
    logic                        w_squash;

    assign w_in_req  = (r_state == S_REQ);
    assign w_ack_req = w_in_req && inst_mem_ack;
    // Once redirected, the PC already points at the new stream
    assign w_inc     = w_ack_req && !r_redir;

`ifdef FETCH_FLUSH_EN
    assign w_squash  = w_ack_req && (r_redir || branch_taken);
`else
    assign w_squash  = 1'b0;
`endif

    assign inst_mem_req  = w_in_req;
    assign inst_mem_addr = r_addr;
    assign fetch_busy    = w_in_req && !inst_mem_ack;

    pc_register #(
        .W        (PC_DATA_WIDTH),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk       (clk),
        .i_rst     (rst),
        .i_load    (branch_taken),
        .i_target  (branch_target),
        .i_inc     (w_inc),
        .o_pc_next (w_pc_next)
    );

    // Fetch FSM with registered IF/ID outputs and request address
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_addr     <= RESET_PC;
            r_redir    <= 1'b0;
            inst_out   <= W_NOP;
            pc_out     <= '0;
            inst_valid <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    inst_valid <= 1'b0;
                    if (en && !stall) begin
                        r_state <= S_REQ;
                        r_addr  <= w_pc_next;
                    end
                end
                S_REQ: begin
                    if (inst_mem_ack) begin
                        r_redir <= 1'b0;
                        if (w_squash) begin
                            inst_valid <= 1'b0;
                            inst_out   <= W_NOP;
                        end else begin
                            inst_valid <= 1'b1;
                            inst_out   <= inst_mem_rdata;
                            pc_out     <= r_addr +
                                PC_DATA_WIDTH'(PC_INCREMENT);
                        end
                        if (stall)
                            r_state <= S_HOLD;
                        else if (en)
                            r_addr <= w_pc_next;
                        else
                            r_state <= S_IDLE;
                    end else begin
                        inst_valid <= 1'b0;
                        if (branch_taken)
                            r_redir <= 1'b1;
                    end
                end
                S_HOLD: begin
`ifdef FETCH_FLUSH_EN
                    if (branch_taken) begin
                        inst_valid <= 1'b0;
                        inst_out   <= W_NOP;
                    end
`endif
                    if (!stall) begin
                        inst_valid <= 1'b0;
                        if (en) begin
                            r_state <= S_REQ;
                            r_addr  <= w_pc_next;
                        end else begin
                            r_state <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_fetch.sv
// Self-checking bench for instruction_fetch: directed steps,
// memory model, and an expected-delivery queue checked on each ack.
module tb_instruction_fetch;

    typedef struct {
        logic [19:0] addr;
        bit          valid;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        stall;
    logic        branch_taken;
    logic [19:0] branch_target;
    logic        inst_mem_req;
    logic [19:0] inst_mem_addr;
    logic        inst_mem_ack;
    logic [31:0] inst_mem_rdata;
    logic [19:0] pc_out;
    logic [31:0] inst_out;
    logic        inst_valid;
    logic        fetch_busy;

    logic        w_en;
    logic        w_req;
    logic [19:0] w_addr;
    logic        w_ack;
    logic [19:0] w_pc_out;
    logic [31:0] w_inst_out;
    logic        w_valid;
    logic        w_busy;

    int nerr = 0;
    int nchk = 0;
    int mem_delay = 0;
    int wcnt = 0;
    bit force_ack = 1'b0;
    bit flush_on;
    exp_t q[$];

    always #5 clk = ~clk;

    instruction_fetch u_dut (
        .clk            (clk),
        .rst            (rst),
        .en             (en),
        .stall          (stall),
        .branch_taken   (branch_taken),
        .branch_target  (branch_target),
        .inst_mem_req   (inst_mem_req),
        .inst_mem_addr  (inst_mem_addr),
        .inst_mem_ack   (inst_mem_ack),
        .inst_mem_rdata (inst_mem_rdata),
        .pc_out         (pc_out),
        .inst_out       (inst_out),
        .inst_valid     (inst_valid),
        .fetch_busy     (fetch_busy)
    );

    assign w_ack = w_req;

    instruction_fetch #(.RESET_PC(20'hFFFFC)) u_wrap (
        .clk            (clk),
        .rst            (rst),
        .en             (w_en),
        .stall          (1'b0),
        .branch_taken   (1'b0),
        .branch_target  (20'h0),
        .inst_mem_req   (w_req),
        .inst_mem_addr  (w_addr),
        .inst_mem_ack   (w_ack),
        .inst_mem_rdata (32'h1234_5678),
        .pc_out         (w_pc_out),
        .inst_out       (w_inst_out),
        .inst_valid     (w_valid),
        .fetch_busy     (w_busy)
    );

    function automatic logic [31:0] mk(input logic [19:0] a);
        return {12'hC3A, a};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Memory model: ack after mem_delay wait cycles, data derived from addr
    always @(negedge clk) begin
        if (inst_mem_ack || !inst_mem_req) wcnt = 0;
        if (inst_mem_req && !force_ack) begin
            if (wcnt >= mem_delay) begin
                inst_mem_ack   = 1'b1;
                inst_mem_rdata = mk(inst_mem_addr);
            end else begin
                inst_mem_ack   = 1'b0;
                inst_mem_rdata = 32'h0;
                wcnt++;
            end
        end else begin
            inst_mem_ack   = force_ack;
            inst_mem_rdata = force_ack ? 32'hDEAD_BEEF : 32'h0;
        end
    end

    // Scoreboard: every accepted ack must match the next expected delivery
    always @(posedge clk) begin
        logic        ae;
        logic [19:0] a;
        exp_t        e;
        ae = inst_mem_ack && inst_mem_req && !rst;
        a  = inst_mem_addr;
        #1;
        if (ae) begin
            if (q.size() == 0) begin
                chk("unexpected_ack", {12'h0, a}, 32'hFFFF_FFFF);
            end else begin
                e = q.pop_front();
                chk("ack_addr", {12'h0, a}, {12'h0, e.addr});
                chk("deliver_valid", {31'h0, inst_valid}, {31'h0, e.valid});
                chk("deliver_inst", inst_out, e.valid ? mk(e.addr) : 32'h0);
                if (e.valid)
                    chk("deliver_pc", {12'h0, pc_out},
                        {12'h0, e.addr + 20'd4});
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef FETCH_FLUSH_EN
        flush_on = 1'b1;
`else
        flush_on = 1'b0;
`endif
        rst = 1'b1; en = 1'b0; stall = 1'b0; w_en = 1'b0;
        branch_taken = 1'b0; branch_target = 20'h0;
        inst_mem_ack = 1'b0; inst_mem_rdata = 32'h0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_valid", {31'h0, inst_valid}, 32'h0);
        chk("rst_inst", inst_out, 32'h0);
        chk("rst_pc_out", {12'h0, pc_out}, 32'h0);
        chk("rst_req", {31'h0, inst_mem_req}, 32'h0);
        chk("rst_addr", {12'h0, inst_mem_addr}, 32'h0);
        chk("rst_busy", {31'h0, fetch_busy}, 32'h0);

        // Zero-wait back-to-back stream 0,4,8,12
        q.push_back('{20'h0, 1'b1});
        q.push_back('{20'h4, 1'b1});
        q.push_back('{20'h8, 1'b1});
        q.push_back('{20'hC, 1'b1});
        en = 1'b1;
        tick();
        chk("b2b_req", {31'h0, inst_mem_req}, 32'h1);
        tick();
        tick(); chk("b2b_valid1", {31'h0, inst_valid}, 32'h1);
        tick(); chk("b2b_valid2", {31'h0, inst_valid}, 32'h1);
        en = 1'b0;
        tick(); chk("b2b_valid3", {31'h0, inst_valid}, 32'h1);
        tick();
        chk("b2b_end_valid", {31'h0, inst_valid}, 32'h0);
        chk("b2b_end_req", {31'h0, inst_mem_req}, 32'h0);

        // Three-cycle ack delay, en dropped mid-request
        mem_delay = 3;
        q.push_back('{20'h10, 1'b1});
        en = 1'b1;
        tick();
        en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk); #1;
            chk("dly_busy", {31'h0, fetch_busy}, 32'h1);
            chk("dly_addr", {12'h0, inst_mem_addr}, 32'h10);
        end
        @(negedge clk); #1;
        chk("dly_busy_ack", {31'h0, fetch_busy}, 32'h0);
        tick();
        tick();
        chk("dly_single_pulse", {31'h0, inst_valid}, 32'h0);
        chk("dly_no_req", {31'h0, inst_mem_req}, 32'h0);
        mem_delay = 0;

        // Stall on the ack cycle -> hold
        q.push_back('{20'h14, 1'b1});
        en = 1'b1;
        tick();
        stall = 1'b1;
        tick();
        chk("hold_req", {31'h0, inst_mem_req}, 32'h0);
        tick();
        chk("hold_valid", {31'h0, inst_valid}, 32'h1);
        chk("hold_inst", inst_out, mk(20'h14));
        chk("hold_pc", {12'h0, pc_out}, 32'h18);
        chk("hold_req2", {31'h0, inst_mem_req}, 32'h0);
        stall = 1'b0;
        q.push_back('{20'h18, 1'b1});
        tick();
        chk("hold_resume_req", {31'h0, inst_mem_req}, 32'h1);
        chk("hold_resume_addr", {12'h0, inst_mem_addr}, 32'h18);
        chk("hold_resume_valid", {31'h0, inst_valid}, 32'h0);
        en = 1'b0;
        tick(); tick();

        // Redirect during outstanding fetch of 0x08
        branch_taken = 1'b1; branch_target = 20'h8;
        tick();
        branch_taken = 1'b0;
        mem_delay = 2;
        q.push_back('{20'h8, !flush_on});
        q.push_back('{20'h100, 1'b1});
        en = 1'b1;
        tick();
        chk("br_addr_orig", {12'h0, inst_mem_addr}, 32'h8);
        branch_taken = 1'b1; branch_target = 20'h100;
        tick();
        branch_taken = 1'b0;
        chk("br_addr_stable", {12'h0, inst_mem_addr}, 32'h8);
        tick(); tick();
        chk("br_new_addr", {12'h0, inst_mem_addr}, 32'h100);
        chk("br_new_req", {31'h0, inst_mem_req}, 32'h1);
        en = 1'b0;
        for (int i = 0; i < 20 && inst_mem_req; i++) tick();
        chk("br_drain", {31'h0, inst_mem_req}, 32'h0);
        mem_delay = 0;

        // Redirect in the same cycle as ack
        q.push_back('{20'h104, !flush_on});
        q.push_back('{20'h200, 1'b1});
        en = 1'b1;
        tick();
        branch_taken = 1'b1; branch_target = 20'h200; en = 1'b0;
        tick();
        branch_taken = 1'b0; en = 1'b1;
        tick();
        chk("brack_addr", {12'h0, inst_mem_addr}, 32'h200);
        en = 1'b0;
        tick(); tick();

        // Reset mid-request, late ack ignored
        mem_delay = 5;
        en = 1'b1;
        tick();
        rst = 1'b1; en = 1'b0;
        tick();
        rst = 1'b0; force_ack = 1'b1;
        tick();
        chk("rstm_valid", {31'h0, inst_valid}, 32'h0);
        chk("rstm_inst", inst_out, 32'h0);
        chk("rstm_pc_out", {12'h0, pc_out}, 32'h0);
        chk("rstm_req", {31'h0, inst_mem_req}, 32'h0);
        chk("rstm_addr", {12'h0, inst_mem_addr}, 32'h0);
        force_ack = 1'b0;
        mem_delay = 0;
        q.push_back('{20'h0, 1'b1});
        en = 1'b1;
        tick();
        chk("rstm_restart", {12'h0, inst_mem_addr}, 32'h0);
        en = 1'b0;
        tick(); tick();

        // PC wrap from RESET_PC 0xFFFFC
        w_en = 1'b1;
        tick();
        chk("wrap_addr0", {12'h0, w_addr}, 32'hFFFFC);
        tick();
        chk("wrap_addr1", {12'h0, w_addr}, 32'h0);
        chk("wrap_pc_out", {12'h0, w_pc_out}, 32'h0);
        chk("wrap_valid", {31'h0, w_valid}, 32'h1);
        w_en = 1'b0;
        tick(); tick();

        chk("queue_empty", q.size(), 32'h0);
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 Parameters, one per line: name, default, meaning.
- PC_DATA_WIDTH, 20, PC and instruction-address width.
- INSTRUCTION_WIDTH, 32, instruction word width.
- RESET_PC, 0, PC value loaded at reset.

REQ-002 Ports, one per line: name, direction, width, meaning.
- clk  in  1  single clock, rising edge; reset is synchronous and active-high.
- rst  in  1  synchronous active-high reset.
- en  in  1  fetch enable.
- stall  in  1  hazard stall; no new fetch, hold delivered instruction.
- branch_taken  in  1  one-cycle redirect pulse.
- branch_target  in  PC_DATA_WIDTH  redirect PC.
- inst_mem_req  out  1  memory request.
- inst_mem_addr  out  PC_DATA_WIDTH  request address.
- inst_mem_ack  in  1  data valid on inst_mem_rdata.
- inst_mem_rdata  in  INSTRUCTION_WIDTH  returned instruction.
- pc_out  out  PC_DATA_WIDTH  fetched address + 4, to IF/ID.
- inst_out  out  INSTRUCTION_WIDTH  fetched instruction, to IF/ID.
- inst_valid  out  1  inst_out/pc_out valid for IF/ID capture.
- fetch_busy  out  1  request outstanding without ack; pipeline stall request.

Function
REQ-003 FSM states: S_IDLE, S_REQ, S_HOLD.
REQ-004 S_IDLE: inst_mem_req=0; go to S_REQ when en=1 and stall=0.
REQ-005 S_REQ: inst_mem_req=1, inst_mem_addr=pc; req and addr stay stable until ack, regardless of en/stall.
REQ-006 fetch_busy = (state==S_REQ) and not inst_mem_ack; combinational.
REQ-007 Ack in S_REQ (not squashed): next edge inst_out<=inst_mem_rdata, pc_out<=addr+4, inst_valid<=1, pc<=pc+4 (redirect has priority).
REQ-008 After ack: en=1 and stall=0 -> stay S_REQ (back-to-back, one instruction per cycle with zero-wait memory); stall=1 -> S_HOLD; en=0 and stall=0 -> S_IDLE.
REQ-009 inst_valid high exactly one cycle per delivered instruction while stall=0; in S_HOLD inst_valid, inst_out, pc_out held until stall=0, then S_REQ if en=1, else S_IDLE.
REQ-010 PC arithmetic: +4 modulo 2^PC_DATA_WIDTH; wrap from max-3 to 0, no flag.
REQ-011 branch_taken: pc<=branch_target next edge in any state; takes priority over increment on simultaneous ack.
REQ-012 branch_taken in S_REQ without same-cycle ack: current request completes at its original address; returned data handled per REQ-016/017; next request uses branch_target.
REQ-013 stall and branch_taken together: redirect applied, no new request while stall=1.
REQ-014 en=0 mid-request: request completes normally; no new request issued.

Reset
REQ-015 rst=1 at an edge: state<=S_IDLE, pc<=RESET_PC, inst_mem_req=0, inst_mem_addr=RESET_PC, inst_out=0, pc_out=0, inst_valid=0, squash flag=0; an outstanding request is abandoned and a late ack after reset is ignored in S_IDLE.

Configuration
REQ-016 FETCH_FLUSH_EN defined: instruction returned for an address issued before a redirect (including ack in the same cycle as branch_taken) is squashed -- no inst_valid, inst_out<=0 (NOP); redirect in S_HOLD clears inst_valid and zeroes inst_out.
REQ-017 FETCH_FLUSH_EN undefined: no squash; that instruction is delivered normally (delay-slot semantics); only the PC is redirected.

Structure
REQ-018 Shared package fetch_pkg: state encodings, PC_INCREMENT=4, NOP_INSTRUCTION=0.
REQ-019 One sub-module pc_register: PC flop with sync reset to RESET_PC, load (redirect) over increment priority.

Verification
REQ-020 Reset, en=1, zero-wait memory returning addr-derived data -> inst_mem_addr 0,4,8,12 on consecutive cycles; pc_out 4,8,12,16; inst_valid continuously high.
REQ-021 Ack delayed 3 cycles -> req/addr stable for 3 cycles, fetch_busy=1 for those cycles, single inst_valid pulse.
REQ-022 stall=1 on ack cycle for 2 cycles -> S_HOLD, inst_out/pc_out stable, inst_valid high, no new req until stall=0.
REQ-023 branch_taken, target 0x100, during outstanding fetch of 0x08 -> next addr 0x100; with FETCH_FLUSH_EN no inst_valid for 0x08 and inst_out=0; without it 0x08 delivered, pc_out=0x0C.
REQ-024 RESET_PC=0xFFFFC, en=1 -> addresses 0xFFFFC then 0x00000.
REQ-025 rst asserted mid-request, then ack -> outputs zero, req=0, ack ignored, fetch restarts at RESET_PC.
